// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric
// Registered request/acknowledge interconnect between the CPU data port and
// N_SLAVES memory-mapped slaves. Each slave owns a 2^REGION_BITS byte region;
// the slave index is m_addr[ADDR_W-1:REGION_BITS]. Indices at or above
// N_SLAVES are unmapped and complete immediately with m_err=1.
//
// Optional feature macro: MMIO_TIMEOUT_EN
//   When defined, a WAIT-state counter aborts a transaction with m_err=1
//   after TIMEOUT_CYCLES cycles without an ack from the selected slave.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_req, m_write    master request strobe (sampled in IDLE) and direction
//   m_addr, m_be      master byte address and byte enables
//   m_wdata           master write data
//   m_ack             one-cycle completion pulse
//   m_rdata, m_err    read data / error flag, valid while m_ack=1
//   busy              high while a transaction is in flight (WAIT, RESP)
//   s_sel             one-hot slave select, held through WAIT
//   s_write, s_addr   latched direction and in-region offset
//   s_be, s_wdata     latched byte enables and write data
//   s_ack             per-slave completion
//   s_rdata           packed per-slave read data, slave k at [32k+31:32k]
module mmio_bus_fabric #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned REGION_BITS    = 8,
    parameter int unsigned N_SLAVES       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_req,
    input  logic                     m_write,
    input  logic [ADDR_W-1:0]        m_addr,
    input  logic [3:0]               m_be,
    input  logic [31:0]              m_wdata,
    output logic                     m_ack,
    output logic [31:0]              m_rdata,
    output logic                     m_err,
    output logic                     busy,
    output logic [N_SLAVES-1:0]      s_sel,
    output logic                     s_write,
    output logic [REGION_BITS-1:0]   s_addr,
    output logic [3:0]               s_be,
    output logic [31:0]              s_wdata,
    input  logic [N_SLAVES-1:0]      s_ack,
    input  logic [32*N_SLAVES-1:0]   s_rdata
);

    localparam int unsigned IDX_W = ADDR_W - REGION_BITS;

    // Reject configurations the decoder cannot represent.
    if (N_SLAVES < 1 || N_SLAVES > (1 << IDX_W)) begin : g_bad_n_slaves
        $error("mmio_bus_fabric: N_SLAVES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mmio_bus_fabric: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    m_ack_q, m_ack_d;
    logic [31:0]             m_rdata_q, m_rdata_d;
    logic                    m_err_q, m_err_d;
    logic                    busy_q, busy_d;
    logic [N_SLAVES-1:0]     s_sel_q, s_sel_d;
    logic                    s_write_q, s_write_d;
    logic [REGION_BITS-1:0]  s_addr_q, s_addr_d;
    logic [3:0]              s_be_q, s_be_d;
    logic [31:0]             s_wdata_q, s_wdata_d;

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    logic [IDX_W-1:0]        idx;
    logic [N_SLAVES-1:0]     sel_dec;
    logic                    ack_hit;
    logic [31:0]             rdata_mux;

    // Region decode of the incoming address into a one-hot select.
    always_comb begin
        idx     = m_addr[ADDR_W-1:REGION_BITS];
        sel_dec = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            sel_dec[k] = (idx == IDX_W'(k));
        end
    end

    // Only the selected slave's ack and data are observed; stray acks are masked.
    always_comb begin
        ack_hit   = |(s_ack & s_sel_q);
        rdata_mux = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (s_sel_q[k]) begin
                rdata_mux = rdata_mux | s_rdata[32*k +: 32];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        s_sel_d   = s_sel_q;
        s_write_d = s_write_q;
        s_addr_d  = s_addr_q;
        s_be_d    = s_be_q;
        s_wdata_d = s_wdata_q;
`ifdef MMIO_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    s_write_d = m_write;
                    s_addr_d  = m_addr[REGION_BITS-1:0];
                    s_be_d    = m_be;
                    s_wdata_d = m_wdata;
                    if (32'(idx) < N_SLAVES) begin
                        state_d = ST_WAIT;
                        s_sel_d = sel_dec;
`ifdef MMIO_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Unmapped: answer directly, never touch a slave.
                        state_d   = ST_RESP;
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes priority over a timeout reached in the same cycle.
                if (ack_hit) begin
                    state_d   = ST_RESP;
                    s_sel_d   = '0;
                    m_err_d   = 1'b0;
                    m_rdata_d = s_write_q ? 32'd0 : rdata_mux;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_RESP;
                    s_sel_d   = '0;
                    m_err_d   = 1'b1;
                    m_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RESP always lasts one cycle, so entering it yields a single-cycle ack.
        m_ack_d = (state_d == ST_RESP);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_ack_q   <= 1'b0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
            busy_q    <= 1'b0;
            s_sel_q   <= '0;
            s_write_q <= 1'b0;
            s_addr_q  <= '0;
            s_be_q    <= '0;
            s_wdata_q <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_ack_q   <= m_ack_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
            busy_q    <= busy_d;
            s_sel_q   <= s_sel_d;
            s_write_q <= s_write_d;
            s_addr_q  <= s_addr_d;
            s_be_q    <= s_be_d;
            s_wdata_q <= s_wdata_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign m_ack   = m_ack_q;
    assign m_rdata = m_rdata_q;
    assign m_err   = m_err_q;
    assign busy    = busy_q;
    assign s_sel   = s_sel_q;
    assign s_write = s_write_q;
    assign s_addr  = s_addr_q;
    assign s_be    = s_be_q;
    assign s_wdata = s_wdata_q;

endmodule

// File: doc/mmio_bus_fabric.md
Name: mmio_bus_fabric

Overview:
Parametrised memory-mapped interconnect between the RV32I CPU data port and N peripheral slaves (boot ROM port 2, data RAM, GPO, future timers/UART).
- Replaces the fixed one-bit address split and combinational read mux with a registered request/acknowledge transaction engine.
- Adds per-slave wait states, unmapped-address error reporting and an optional bus timeout.
- Sits between the CPU and all memory-mapped slaves inside the computer top level.

Parameters:
ADDR_W, 10, master address width in bits
REGION_BITS, 8, log2 of each slave's region size in bytes; slave index = m_addr[ADDR_W-1:REGION_BITS]
N_SLAVES, 3, number of slave channels, 1..2^(ADDR_W-REGION_BITS)
TIMEOUT_CYCLES, 16, WAIT-state cycle limit before error (only with MMIO_TIMEOUT_EN), >=1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
m_req  in  1  master request; sampled only in IDLE
m_write  in  1  1=write, 0=read
m_addr  in  ADDR_W  byte address
m_be  in  4  byte enables (CPU width field)
m_wdata  in  32  write data
m_ack  out  1  one-cycle transaction completion pulse
m_rdata  out  32  read data, valid while m_ack=1
m_err  out  1  error flag, valid while m_ack=1
busy  out  1  high in WAIT and RESP
s_sel  out  N_SLAVES  one-hot slave select, held for the whole WAIT state
s_write  out  1  latched m_write
s_addr  out  REGION_BITS  latched offset m_addr[REGION_BITS-1:0]
s_be  out  4  latched m_be
s_wdata  out  32  latched m_wdata
s_ack  in  N_SLAVES  per-slave completion; may be asserted in the first cycle its select is high
s_rdata  in  32*N_SLAVES  slave k read data at bits [32k+31:32k]

Behaviour:
- Reset (rst=1 at the edge): state=IDLE. Outputs forced to 0: m_ack, m_rdata, m_err, busy, s_sel, s_write, s_addr, s_be, s_wdata. Timeout counter cleared.
- Reset mid-transaction: the transaction is abandoned. No m_ack is issued, and s_sel drops on the next cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE, m_req=1: latch write/addr/be/wdata and decode idx.
  - idx < N_SLAVES: go to WAIT with s_sel[idx]=1.
  - idx >= N_SLAVES (unmapped): go to RESP with m_err=1, m_rdata=0. No select is asserted and no slave side effect occurs.
- IDLE, m_req=0: stay in IDLE.
- WAIT:
  - s_ack[idx]=1: capture m_rdata = s_rdata slice idx for a read, 0 for a write. Set m_err=0, clear s_sel, go to RESP.
  - s_ack bits of non-selected slaves are ignored.
- RESP: m_ack=1 for exactly one cycle, then return to IDLE. m_rdata and m_err hold their values until the next capture.
- Minimum latency with a zero-wait slave: req sampled at edge 0 → WAIT; ack sampled at edge 1 → m_ack high in cycle 2. Each slave wait state adds one cycle.
- m_req while busy=1 is ignored; there is no queueing.
  - The master deasserts m_req in the cycle it sees m_ack.
  - If m_req is still high in the following IDLE cycle, a new transaction starts (back-to-back is legal).
- s_write/s_addr/s_be/s_wdata stay stable from WAIT entry until the next transaction is latched.
- Width rules:
  - s_addr drops the upper index bits.
  - Byte selection within the word is the slave's job using s_be; the fabric passes all 32 bits unmodified.

Optional Feature:
MMIO_TIMEOUT_EN
- Defined: a counter increments each WAIT cycle without s_ack[idx]. When the count reaches TIMEOUT_CYCLES with no ack, clear s_sel, set m_err=1 and m_rdata=0, and go to RESP. An ack arriving in the same cycle the limit is reached wins (normal completion, m_err=0). The counter clears on WAIT entry.
- Undefined: no counter is synthesised and WAIT lasts indefinitely. m_err is raised only for unmapped addresses.

Test Plan:
- Reset: rst=1 for 2 cycles during WAIT → s_sel=0, busy=0, no m_ack pulse, next request proceeds normally.
- Zero-wait read: slave 1 ties s_ack=1 with s_rdata=0xDEADBEEF; read of m_addr=0x104 → s_sel=3'b010, s_addr=0x04, m_ack exactly 2 cycles after req with m_rdata=0xDEADBEEF, m_err=0.
- Wait states and write: slave 2 acks 3 cycles after select; write m_addr=0x2F0, m_wdata=0x000000A5, m_be=4'b0001 → s_wdata/s_be stable all 3 cycles, m_ack at cycle 5, m_rdata=0.
- Unmapped: read m_addr=0x3FC with N_SLAVES=3 → s_sel never asserted, m_ack at cycle 1, m_err=1, m_rdata=0.
- Back-to-back and stray acks: hold m_req high for two transactions while toggling s_ack[0] during a slave-1 access → each transaction is acked once, the stray ack is ignored, and the second transaction starts the cycle after the first RESP.
- Timeout (MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave 0 never acks → m_ack with m_err=1 after 16 WAIT cycles. Rerun with the ack arriving exactly at the limit → m_err=0.
